// File: rtl/dff_mem_burst_if.sv
// Command, write-data and read-data handshakes between a burst
// initiator and dff_mem_burst_ctrl.
interface dff_mem_burst_if #(
  parameter int ADDR_BITS = 5
) ();
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [ADDR_BITS-1:0] cmd_len;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [7:0]           wr_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [7:0]           rd_data;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/dff_mem_burst_ctrl.sv
// Burst command sequencer in front of the DFF byte memory:
// one write per accepted byte, reads issued one address at a time.
module dff_mem_burst_ctrl #(
  parameter int RAM_BYTES = 32,
  parameter int ADDR_BITS = $clog2(RAM_BYTES)
) (
  input  logic                 clk,
  input  logic                 rst,
  dff_mem_burst_if.slave       bus,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_wr_en,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_SET,
    RD_WAIT,
    RD_OUT
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST =
    ADDR_BITS'(RAM_BYTES - 1);

  state_t               state;
  logic [ADDR_BITS-1:0] addr;
  logic [ADDR_BITS-1:0] cnt;

  function automatic logic [ADDR_BITS-1:0] nxt(
    input logic [ADDR_BITS-1:0] a
  );
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  assign bus.cmd_ready = (state == IDLE);
  assign bus.wr_ready  = (state == WR);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      cnt         <= '0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wdata   <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
      done        <= 1'b0;
    end else begin
      done      <= 1'b0;
      mem_wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            cnt      <= bus.cmd_len;
            addr     <= bus.cmd_addr;
            mem_addr <= bus.cmd_addr;
            state    <= bus.cmd_write ? WR : RD_SET;
          end
        end
        WR: begin
          if (bus.wr_valid) begin
            mem_wr_en <= 1'b1;
            mem_wdata <= bus.wr_data;
            mem_addr  <= addr;
            addr      <= nxt(addr);
            if (cnt == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        RD_SET: state <= RD_WAIT;
        RD_WAIT: begin
          bus.rd_data  <= mem_rdata;
          bus.rd_valid <= 1'b1;
          state        <= RD_OUT;
        end
        RD_OUT: begin
          if (bus.rd_ready) begin
            bus.rd_valid <= 1'b0;
            if (cnt == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              cnt      <= cnt - 1'b1;
              addr     <= nxt(addr);
              mem_addr <= nxt(addr);
              state    <= RD_SET;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_mem_burst_ctrl.sv
// Randomised bench for dff_mem_burst_ctrl with a transaction-level
// reference model and a registered-read byte memory.
module tb_dff_mem_burst_ctrl;
  localparam int N  = 32;
  localparam int AB = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic          done;
  logic [AB-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  always #5 clk = ~clk;

  dff_mem_burst_if #(.ADDR_BITS(AB)) bus ();

  dff_mem_burst_ctrl #(.RAM_BYTES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [7:0] ram [N];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) ram[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_wr_en) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // reference model: burst-level view of the controller
  bit         m_init = 0;
  bit         m_busy, m_wr;
  bit         exp_wen, exp_done, after_rst;
  int         m_left, m_addr, m_ph, exp_waddr;
  logic [7:0] exp_wdata;
  logic [7:0] ref_mem [N];

  always @(posedge clk) begin
    exp_wen   = 0;
    exp_done  = 0;
    after_rst = 0;
    if (rst) begin
      m_init = 1; after_rst = 1;
      m_busy = 0; m_wr = 0;
      m_left = 0; m_addr = 0; m_ph = 0;
      for (int i = 0; i < N; i++) ref_mem[i] = '0;
    end else if (m_init) begin
      if (!m_busy) begin
        if (bus.cmd_valid) begin
          m_busy = 1;
          m_wr   = bus.cmd_write;
          m_left = int'(bus.cmd_len);
          m_addr = int'(bus.cmd_addr);
          m_ph   = 0;
        end
      end else if (m_wr) begin
        if (bus.wr_valid) begin
          exp_wen   = 1;
          exp_waddr = m_addr;
          exp_wdata = bus.wr_data;
          ref_mem[AB'(m_addr)] = bus.wr_data;
          m_addr = (m_addr + 1) % N;
          if (m_left == 0) begin
            m_busy = 0; exp_done = 1;
          end else m_left--;
        end
      end else begin
        if (m_ph < 2) m_ph++;
        else if (bus.rd_ready) begin
          if (m_left == 0) begin
            m_busy = 0; exp_done = 1;
          end else begin
            m_left--;
            m_addr = (m_addr + 1) % N;
            m_ph = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      bit rv;
      rv = m_busy && !m_wr && m_ph >= 2;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy));
      chk("wr_ready", 32'(bus.wr_ready),
          32'(m_busy && m_wr));
      chk("done", 32'(done), 32'(exp_done));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(exp_wen));
      if (exp_wen) begin
        chk("wr_addr", 32'(mem_addr), 32'(exp_waddr));
        chk("wr_data", 32'(mem_wdata), 32'(exp_wdata));
      end
      chk("rd_valid", 32'(bus.rd_valid), 32'(rv));
      if (rv)
        chk("rd_data", 32'(bus.rd_data),
            32'(ref_mem[AB'(m_addr)]));
      if (m_busy && !m_wr && m_ph < 2)
        chk("rd_addr", 32'(mem_addr), 32'(m_addr));
      if (after_rst) begin
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rdata", 32'(bus.rd_data), 32'd0);
      end
    end
  end

  logic [7:0] rd_q [$];
  int         wa_q [$];
  logic [7:0] wd_q [$];
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_valid && bus.rd_ready)
        rd_q.push_back(bus.rd_data);
      if (done) done_cnt++;
    end
    if (mem_wr_en) begin
      wa_q.push_back(int'(mem_addr));
      wd_q.push_back(mem_wdata);
    end
  end

  task automatic clr();
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    done_cnt = 0;
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(bit w, int a, int l);
    int n = 0;
    bus.cmd_valid = 1;
    bus.cmd_write = w;
    bus.cmd_addr  = AB'(a);
    bus.cmd_len   = AB'(l);
    @(negedge clk);
    while (!bus.cmd_ready && n < 300) begin
      @(negedge clk); n++;
    end
    chk("cmd_accept", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 0;
  endtask

  task automatic wr_byte(logic [7:0] d, int stall);
    int n = 0;
    while ($urandom_range(0, 99) < stall) begin
      bus.wr_valid = 0;
      bus.wr_data  = 8'($urandom);
      tick();
    end
    bus.wr_valid = 1;
    bus.wr_data  = d;
    @(negedge clk);
    while (!bus.wr_ready && n < 300) begin
      @(negedge clk); n++;
    end
    chk("wr_accept", 32'(bus.wr_ready), 32'd1);
    @(posedge clk); #1;
    bus.wr_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("idle_wait", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic collect(int cnt, int pct);
    int n = 0;
    while (rd_q.size() < cnt && n < 3000) begin
      bus.rd_ready = ($urandom_range(0, 99) < pct);
      bus.wr_valid = 1'($urandom);
      bus.wr_data  = 8'($urandom);
      tick(); n++;
    end
    bus.rd_ready = 0;
    bus.wr_valid = 0;
    chk("rd_count", 32'(rd_q.size()), 32'(cnt));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] wb [4];
    int         ea [4];
    int         pat [6];
    int         eb [3];
    int         n;

    bus.cmd_valid = 0; bus.cmd_write = 0;
    bus.cmd_addr  = '0; bus.cmd_len = '0;
    bus.wr_valid  = 0; bus.wr_data = '0;
    bus.rd_ready  = 0;
    rst = 1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_wen", 32'(mem_wr_en), 32'd0);
    chk("reset_rvalid", 32'(bus.rd_valid), 32'd0);
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    rst = 0;
    tick(2);

    // write burst wrapping past the top address
    clr();
    wb = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    ea = '{30, 31, 0, 1};
    send_cmd(1, 30, 3);
    for (int i = 0; i < 4; i++) wr_byte(wb[i], 0);
    wait_idle();
    tick(2);
    chk("wrap_pulses", 32'(wa_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      chk("wrap_addr", 32'(wa_q[i]), 32'(ea[i]));
      chk("wrap_data", 32'(wd_q[i]), 32'(wb[i]));
    end
    chk("wrap_done", 32'(done_cnt), 32'd1);
    clr();
    send_cmd(0, 30, 3);
    collect(4, 100);
    wait_idle();
    for (int i = 0; i < 4 && i < rd_q.size(); i++)
      chk("wrap_read", 32'(rd_q[i]), 32'(wb[i]));

    // read with consumer backpressure
    send_cmd(1, 5, 1);
    wr_byte(8'h5A, 0);
    wr_byte(8'hC3, 0);
    wait_idle();
    clr();
    bus.rd_ready = 0;
    send_cmd(0, 5, 1);
    n = 0;
    while (!bus.rd_valid && n < 50) begin
      tick(); n++;
    end
    chk("bp_valid_up", 32'(bus.rd_valid), 32'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold_data", 32'(bus.rd_data), 32'h5A);
      chk("bp_hold_valid", 32'(bus.rd_valid), 32'd1);
      chk("bp_hold_addr", 32'(mem_addr), 32'd5);
    end
    @(posedge clk); #1;
    collect(2, 100);
    wait_idle();
    tick();
    if (rd_q.size() == 2) begin
      chk("bp_byte0", 32'(rd_q[0]), 32'h5A);
      chk("bp_byte1", 32'(rd_q[1]), 32'hC3);
    end
    chk("bp_done", 32'(done_cnt), 32'd1);

    // full-depth write then read
    send_cmd(1, 0, N - 1);
    for (int i = 0; i < N; i++) wr_byte(8'(i ^ 8'hFF), 20);
    wait_idle();
    clr();
    send_cmd(0, 0, N - 1);
    collect(N, 70);
    wait_idle();
    for (int i = 0; i < N && i < rd_q.size(); i++)
      chk("full_read", 32'(rd_q[i]), 32'(i ^ 8'hFF));

    // second command held during a write burst
    clr();
    eb = '{8'h11, 8'h22, 8'h33};
    send_cmd(1, 10, 2);
    bus.cmd_valid = 1; bus.cmd_write = 0;
    bus.cmd_addr = AB'(10); bus.cmd_len = AB'(2);
    for (int i = 0; i < 3; i++) wr_byte(8'(eb[i]), 30);
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk); n++;
    end
    chk("held_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 0;
    collect(3, 100);
    wait_idle();
    tick();
    for (int i = 0; i < 3 && i < rd_q.size(); i++)
      chk("held_read", 32'(rd_q[i]), 32'(eb[i]));
    chk("held_done", 32'(done_cnt), 32'd2);

    // reset in the middle of a write burst
    clr();
    send_cmd(1, 0, 7);
    wr_byte(8'h77, 0);
    wr_byte(8'h78, 0);
    wr_byte(8'h79, 0);
    rst = 1;
    tick();
    rst = 0;
    tick(5);
    chk("rst_pulses", 32'(wa_q.size()), 32'd3);
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    send_cmd(0, 0, 2);
    collect(3, 100);
    wait_idle();
    for (int i = 0; i < 3 && i < rd_q.size(); i++)
      chk("rst_read", 32'(rd_q[i]), 32'd0);

    // write stalls
    clr();
    pat = '{1, 0, 0, 1, 0, 1};
    send_cmd(1, 20, 2);
    for (int i = 0; i < 6; i++) begin
      bus.wr_valid = 1'(pat[i]);
      bus.wr_data  = 8'(8'hB0 + i);
      tick();
    end
    bus.wr_valid = 0;
    tick(3);
    chk("stall_pulses", 32'(wa_q.size()), 32'd3);
    eb = '{8'hB0, 8'hB3, 8'hB5};
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      chk("stall_addr", 32'(wa_q[i]), 32'(20 + i));
      chk("stall_data", 32'(wd_q[i]), 32'(eb[i]));
    end
    chk("stall_done", 32'(done_cnt), 32'd1);

    // random bursts, checked cycle by cycle by the model
    for (int k = 0; k < 20; k++) begin
      bit w;
      int a, l;
      w = 1'($urandom);
      a = $urandom_range(0, N - 1);
      l = $urandom_range(0, 7);
      clr();
      send_cmd(w, a, l);
      if (w) begin
        for (int i = 0; i <= l; i++)
          wr_byte(8'($urandom), 30);
      end else begin
        collect(l + 1, 60);
      end
      wait_idle();
    end

    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
